lsu_pipelined: RTL
==================

Name: lsu_pipelined

Overview:
- Sequential load/store unit between the execute stage and data memory; next generation of the combinational memory-interface block.
- Accepts one RV32 load/store per transaction, identified by the instruction ID from the shared instruction defines.
- Drives a req/ready memory bus with word-aligned addresses and byte enables, returns the sign/zero-extended load data, and reports misalignment and timeout faults.

Parameters:
ADDR_WIDTH, 32, width of the memory address path; addresses wrap modulo 2^ADDR_WIDTH.
TIMEOUT_CYCLES, 255, cycles a request may wait for mem_ready before faulting; 0 disables the timeout.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  execute stage presents an instruction this cycle
instr_id  in  6  instruction ID (INSTR_LB..INSTR_SW from shared defines)
rs2_value  in  32  store data
mem_addr  in  ADDR_WIDTH  effective byte address
busy  out  1  transaction in progress; start is ignored while high
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result; valid with done, held until next done
fault  out  1  valid with done: misaligned or timeout
fault_addr  out  ADDR_WIDTH  offending byte address, valid with fault
bus_req  out  1  memory request
bus_we  out  1  1 = write
bus_addr  out  ADDR_WIDTH  word-aligned address {addr[AW-1:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned write data
bus_ready  in  1  memory accepts/completes the current beat
bus_rdata  in  32  read data, valid when bus_ready=1 and bus_we=0

Behaviour:
- Reset: all outputs 0, FSM returns to IDLE from any state, timeout counter 0. An in-flight beat is abandoned; bus_req is low after the reset edge.
- States:
  - IDLE (busy=0).
  - ACCESS (bus_req=1).
  - ACCESS2 (second beat, feature only).
  - RESP (done=1, busy=1).
- IDLE transitions:
  - start with a load/store ID latches id, addr and data, then goes to ACCESS.
  - start with any other ID is ignored.
  - A misaligned access with the feature off goes directly to RESP with fault=1; no bus activity occurs.
- ACCESS/ACCESS2:
  - bus_* are registered and held stable until bus_ready is sampled high.
  - On bus_ready the FSM goes to RESP, or to ACCESS2 after the first beat of a split access.
- RESP:
  - done=1 for exactly one cycle, then IDLE.
  - start asserted in the RESP cycle is ignored.
- Latency: start at cycle 0, bus_req at cycle 1. With bus_ready at cycle 1, done is at cycle 2. Each wait-state cycle adds 1.
- Lanes, with off = addr[1:0]:
  - SB: be = 1<<off; wdata = byte replicated into all 4 lanes.
  - SH: be = 4'b0011 or 4'b1100 (by addr[1]); halfword replicated into both halves.
  - SW: be = 4'b1111.
  - Loads drive the same be.
- Load extract:
  - LB/LBU: byte at lane off, sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
  - Stores complete with load_data unchanged.
- Misaligned definition: LH/LHU/SH with addr[0]=1; LW/SW with off!=0.
- Timeout:
  - The counter increments each ACCESS/ACCESS2 cycle with bus_ready low and clears on each new beat.
  - On reaching TIMEOUT_CYCLES, bus_req drops and the FSM goes to RESP with fault=1.
  - fault_addr is the original byte address.
- Faulted loads return load_data=0.
- A first-beat store that already completed is not rolled back.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: a misaligned access is split into two aligned beats.
  - Beat 1 at the aligned address, be = (full_be<<off)&4'hF.
  - Beat 2 at aligned address + 4 (wraps), be = full_be>>(4-off).
  - full_be = 4'b0011 (half) or 4'b1111 (word).
  - Store wdata is rotated left by 8*off and used for both beats.
  - Load bytes from both beats are concatenated, rotated right by 8*off, then extended.
  - Total latency is at least 3 cycles.
- Undefined: a misaligned access faults with no bus activity (2-cycle done).

Decomposition:
- INSTR_* IDs and FSM state encodings live in the shared instruction-defines header.
- One sub-module, lsu_lane_align: combinational byte-enable generation, write-data replication/rotation, load extract/extend. The FSM, counter and registers stay in the top.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, bus_ready held 1 -> bus_addr 0x100, be 4'hF, wdata 0xDEADBEEF, done at cycle 2, fault 0.
- LB addr 0x203, rdata 0x80FF1234 -> be 4'h8, load_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x302, rs2 0x0000ABCD, bus_ready low 3 cycles -> bus signals stable, be 4'hC, wdata 0xABCDABCD, done at cycle 5.
- TIMEOUT_CYCLES=4, LW addr 0x40, bus_ready never high -> bus_req drops after 4 cycles, done with fault=1, fault_addr 0x40, load_data 0.
- LW addr 0x101:
  - Feature off -> no bus_req, done at cycle 2 with fault=1.
  - Feature on, beat1 rdata 0x33221100, beat2 rdata 0x77665544 -> beats at 0x100 (be 4'hE) and 0x104 (be 4'h1), load_data 0x44332211.
- rst pulsed during an ACCESS wait, and start with a non-memory ID -> after the reset edge busy/bus_req/done are 0; the non-memory start produces no bus_req and no done.

Source files
------------

// File: rtl/lsu_pipelined_pkg.sv
// lsu_pipelined_pkg
//   Shared instruction defines for the load/store unit: RV32 load/store
//   instruction IDs, the LSU FSM state encoding and small ID decode helpers.
package lsu_pipelined_pkg;

  localparam logic [5:0] INSTR_LB  = 6'd1;
  localparam logic [5:0] INSTR_LH  = 6'd2;
  localparam logic [5:0] INSTR_LW  = 6'd3;
  localparam logic [5:0] INSTR_LBU = 6'd4;
  localparam logic [5:0] INSTR_LHU = 6'd5;
  localparam logic [5:0] INSTR_SB  = 6'd6;
  localparam logic [5:0] INSTR_SH  = 6'd7;
  localparam logic [5:0] INSTR_SW  = 6'd8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_ACCESS2 = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] id);
    return (id == INSTR_LB) || (id == INSTR_LH) || (id == INSTR_LW) ||
           (id == INSTR_LBU) || (id == INSTR_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] id);
    return (id == INSTR_SB) || (id == INSTR_SH) || (id == INSTR_SW);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
//   Combinational lane steering for the LSU.
//   Ports:
//     i_id          instruction ID
//     i_off         byte offset addr[1:0]
//     i_wdata       store data (rs2)
//     i_rdata_lo    read data of the first (or only) beat
//     i_rdata_hi    low 3 bytes of the second beat (zero when no second beat)
//     o_be_lo       byte enables for the first beat
//     o_be_hi       byte enables for the second beat (zero if it fits in one word)
//     o_wdata       lane-aligned write data
//     o_load_data   extracted and extended load result
//     o_misaligned  access crosses its natural alignment
import lsu_pipelined_pkg::*;

module lsu_lane_align (
  input  logic [5:0]  i_id,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [23:0] i_rdata_hi,
  output logic [3:0]  o_be_lo,
  output logic [3:0]  o_be_hi,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);

  logic [3:0]  w_full_be;
  logic [31:0] w_base;
  logic [7:0]  w_be_wide;
  logic [31:0] w_shift;

  always_comb begin
    w_full_be = 4'b1111;
    w_base    = i_wdata;
    case (i_id)
      INSTR_LB, INSTR_LBU, INSTR_SB: begin
        w_full_be = 4'b0001;
        w_base    = {4{i_wdata[7:0]}};
      end
      INSTR_LH, INSTR_LHU, INSTR_SH: begin
        w_full_be = 4'b0011;
        w_base    = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Upper nibble is whatever spills into the next word.
  assign w_be_wide = {4'b0000, w_full_be} << i_off;
  assign o_be_lo   = w_be_wide[3:0];
  assign o_be_hi   = w_be_wide[7:4];

  // Rotating the replicated data is a no-op for aligned byte/half stores,
  // so one path serves both aligned and split accesses.
  always_comb begin
    o_wdata = w_base;
    case (i_off)
      2'd1:    o_wdata = {w_base[23:0], w_base[31:24]};
      2'd2:    o_wdata = {w_base[15:0], w_base[31:16]};
      2'd3:    o_wdata = {w_base[7:0],  w_base[31:8]};
      default: o_wdata = w_base;
    endcase
  end

  // {hi,lo} shifted right by 8*off puts the addressed data at bit 0.
  always_comb begin
    w_shift = i_rdata_lo;
    case (i_off)
      2'd1:    w_shift = {i_rdata_hi[7:0],  i_rdata_lo[31:8]};
      2'd2:    w_shift = {i_rdata_hi[15:0], i_rdata_lo[31:16]};
      2'd3:    w_shift = {i_rdata_hi[23:0], i_rdata_lo[31:24]};
      default: w_shift = i_rdata_lo;
    endcase
  end

  always_comb begin
    o_load_data = 32'h0;
    case (i_id)
      INSTR_LB:  o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      INSTR_LBU: o_load_data = {24'h0, w_shift[7:0]};
      INSTR_LH:  o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      INSTR_LHU: o_load_data = {16'h0, w_shift[15:0]};
      INSTR_LW:  o_load_data = w_shift;
      default:   o_load_data = 32'h0;
    endcase
  end

  always_comb begin
    o_misaligned = 1'b0;
    case (i_id)
      INSTR_LH, INSTR_LHU, INSTR_SH: o_misaligned = i_off[0];
      INSTR_LW, INSTR_SW:            o_misaligned = |i_off;
      default:                       o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_pipelined.sv
// lsu_pipelined
//   Sequential RV32 load/store unit driving a req/ready memory bus.
//   Optional macro LSU_MISALIGN_SPLIT_EN: misaligned accesses are split into
//   two aligned beats instead of faulting.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     start, instr_id        execute stage request and instruction ID
//     rs2_value, mem_addr    store data and effective byte address
//     busy, done             transaction in progress, completion pulse
//     load_data              extended load result (held until next done)
//     fault, fault_addr      misalign/timeout fault and its byte address
//     bus_req/we/addr/be/wdata  registered memory request
//     bus_ready, bus_rdata   memory handshake and read data
import lsu_pipelined_pkg::*;

module lsu_pipelined #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            instr_id,
  input  logic [31:0]           rs2_value,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t            r_state, w_state_nxt;
  logic [5:0]            r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_split, r_pend_fault;
  logic [31:0]           r_rdata_lo;
  logic [TW-1:0]         r_tcnt;
  logic [31:0]           r_load_data;
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_fault_addr;
  logic                  r_bus_req, r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]            r_bus_be;
  logic [31:0]           r_bus_wdata;

  logic [5:0]  w_id;
  logic [1:0]  w_off;
  logic [3:0]  w_be_lo, w_be_hi;
  logic [31:0] w_wdata, w_load_data, w_rlo;
  logic [23:0] w_rhi;
  logic        w_misaligned, w_accept, w_in_access, w_beat_ok, w_timeout;
  logic        w_split_req, w_mis_fault;

  // In IDLE the lane logic looks at the incoming request; afterwards at the
  // latched one, so load extraction uses the captured ID/offset.
  assign w_id        = (r_state == S_IDLE) ? instr_id      : r_id;
  assign w_off       = (r_state == S_IDLE) ? mem_addr[1:0] : r_addr[1:0];
  assign w_rlo       = (r_state == S_ACCESS2) ? r_rdata_lo : bus_rdata;
  assign w_rhi       = (r_state == S_ACCESS2) ? bus_rdata[23:0] : 24'h0;

  lsu_lane_align u_align (
    .i_id         (w_id),
    .i_off        (w_off),
    .i_wdata      (rs2_value),
    .i_rdata_lo   (w_rlo),
    .i_rdata_hi   (w_rhi),
    .o_be_lo      (w_be_lo),
    .o_be_hi      (w_be_hi),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  assign w_accept    = (r_state == S_IDLE) && start &&
                       (is_load(instr_id) || is_store(instr_id));
  assign w_in_access = (r_state == S_ACCESS) || (r_state == S_ACCESS2);
  assign w_beat_ok   = w_in_access && r_bus_req && bus_ready;
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_in_access && r_bus_req &&
                       !bus_ready && (r_tcnt == TO_LAST);

`ifdef LSU_MISALIGN_SPLIT_EN
  // A misaligned half inside one word (off=1) needs no second beat.
  assign w_split_req = w_misaligned && (w_be_hi != 4'h0);
  assign w_mis_fault = 1'b0;
`else
  assign w_split_req = 1'b0;
  assign w_mis_fault = w_misaligned;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ACCESS;
      // A misalignment fault passes through ACCESS without requesting, which
      // keeps its done at the same cycle as a zero-wait access.
      S_ACCESS: begin
        if (r_pend_fault || w_timeout) w_state_nxt = S_RESP;
        else if (w_beat_ok)            w_state_nxt = r_split ? S_ACCESS2 : S_RESP;
      end
      S_ACCESS2: if (w_beat_ok || w_timeout) w_state_nxt = S_RESP;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id         <= '0;
      r_addr       <= '0;
      r_split      <= 1'b0;
      r_pend_fault <= 1'b0;
      r_rdata_lo   <= '0;
      r_tcnt       <= '0;
      r_load_data  <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_be     <= '0;
      r_bus_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id         <= instr_id;
            r_addr       <= mem_addr;
            r_tcnt       <= '0;
            r_split      <= w_split_req;
            r_pend_fault <= w_mis_fault;
            if (!w_mis_fault) begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= is_store(instr_id);
              r_bus_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
              r_bus_be    <= w_be_lo;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS, S_ACCESS2: begin
          if (r_pend_fault) begin
            r_pend_fault <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_addr <= r_addr;
            if (is_load(r_id)) r_load_data <= '0;
          end else if (w_beat_ok) begin
            r_tcnt <= '0;
            if ((r_state == S_ACCESS) && r_split) begin
              r_rdata_lo <= bus_rdata;
              r_bus_addr <= r_bus_addr + ADDR_WIDTH'(4);
              r_bus_be   <= w_be_hi;
            end else begin
              r_bus_req <= 1'b0;
              r_fault   <= 1'b0;
              if (is_load(r_id)) r_load_data <= w_load_data;
            end
          end else if (w_timeout) begin
            r_bus_req    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_addr <= r_addr;
            if (is_load(r_id)) r_load_data <= '0;
          end else if (r_bus_req) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_RESP);
  assign load_data  = r_load_data;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;

endmodule
